vending_controller: RTL

Multi-product vending controller that sequences the coin-accumulation, vend and change-return datapath. Accumulates credit in 5-unit steps and accepts a product selection when credit covers the price. It then issues a one-cycle vend pulse, decrements per-product inventory and pays back leftover credit as a train of `chg5` pulses. It sits between the coin/keypad front end and the dispenser/change-hopper actuators, replacing the single-price Mealy vend machine.

---
 rtl/vending_pkg.sv | 37 +++
 rtl/vending_inventory.sv | 65 ++++++
 rtl/vending_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the multi-product vending controller:
//   - coin codes as sampled on the coin input
//   - controller state encoding
//   - per-product price table, in units of 5
// -----------------------------------------------------------------------------
package vending_pkg;

    // Coin input codes
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_e;

    // Width of a price value (largest price is 8 units)
    localparam int PRICE_W = 4;

    // Prices in 5-units: 20 / 25 / 30 / 40
    function automatic logic [PRICE_W-1:0] price_of(input logic [1:0] id);
        logic [PRICE_W-1:0] p;
        case (id)
            2'd0:    p = 4'd4;
            2'd1:    p = 4'd5;
            2'd2:    p = 4'd6;
            default: p = 4'd8;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/vending_inventory.sv
// -----------------------------------------------------------------------------
// vending_inventory
// One down-counter per product. Counters load INV_MAX on reset and on restock;
// a decrement request lowers the addressed counter by one, never below zero.
// Restock takes priority over a simultaneous decrement.
//
// Ports:
//   clk_i       : clock, rising edge
//   rst_i       : asynchronous active-high reset (counters -> INV_MAX)
//   restock_i   : reload every counter to INV_MAX
//   dec_en_i    : decrement the counter selected by dec_id_i
//   dec_id_i    : product index to decrement
//   sold_out_o  : bit i high when counter i is zero
// -----------------------------------------------------------------------------
module vending_inventory
    import vending_pkg::*;
#(
    parameter int NPROD   = 4,
    parameter int INV_W   = 4,
    parameter int INV_MAX = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             restock_i,
    input  logic             dec_en_i,
    input  logic [1:0]       dec_id_i,
    output logic [NPROD-1:0] sold_out_o
);

    localparam logic [INV_W-1:0] INV_LOAD = INV_W'(INV_MAX);
    localparam logic [INV_W-1:0] INV_ONE  = INV_W'(1);

    logic [INV_W-1:0] inv_q [NPROD];
    logic [INV_W-1:0] inv_d [NPROD];

    always_comb begin
        for (int i = 0; i < NPROD; i++) begin
            inv_d[i] = inv_q[i];
            if (restock_i) begin
                inv_d[i] = INV_LOAD;
            end else if (dec_en_i && (int'(dec_id_i) == i) && (inv_q[i] != '0)) begin
                inv_d[i] = inv_q[i] - INV_ONE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NPROD; i++) begin
                inv_q[i] <= INV_LOAD;
            end
        end else begin
            for (int i = 0; i < NPROD; i++) begin
                inv_q[i] <= inv_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NPROD; i++) begin
            sold_out_o[i] = (inv_q[i] == '0);
        end
    end

endmodule

// File: rtl/vending_controller.sv
// -----------------------------------------------------------------------------
// vending_controller
// Multi-product vending controller. Accumulates credit in 5-unit steps, accepts
// a product selection when credit covers the price and stock remains, issues a
// one-cycle vend strobe, then returns leftover credit as a train of chg5 pulses.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous active-high reset
//   coin_i         : coin code (00 none, 01 = 5, 10 = 10, 11 invalid)
//   sel_valid_i    : selection request
//   sel_i          : product index for the selection
//   cancel_i       : refund request
//   restock_i      : reload all inventory counters
//   vend_o         : dispense strobe (one cycle)
//   vend_id_o      : product being dispensed, valid with vend_o
//   chg5_o         : return one 5-unit coin this cycle
//   coin_reject_o  : coin sampled at the previous edge was not credited
//   busy_o         : controller is not idle
//   credit_o       : current credit in 5-units
//   sold_out_o     : per-product sold-out flags
// -----------------------------------------------------------------------------
module vending_controller
    import vending_pkg::*;
#(
    parameter int NPROD    = 4,
    parameter int CREDIT_W = 4,
    parameter int INV_W    = 4,
    parameter int INV_MAX  = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          coin_i,
    input  logic                sel_valid_i,
    input  logic [1:0]          sel_i,
    input  logic                cancel_i,
    input  logic                restock_i,
    output logic                vend_o,
    output logic [1:0]          vend_id_o,
    output logic                chg5_o,
    output logic                coin_reject_o,
    output logic                busy_o,
    output logic [CREDIT_W-1:0] credit_o,
    output logic [NPROD-1:0]    sold_out_o
);

    localparam int CREDIT_MAX = (1 << CREDIT_W) - 1;

    // Working width wide enough for credit, prices and credit + 2 without wrap
    localparam int CW = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;
    localparam int EW = CW + 1;

    localparam logic [CREDIT_W-1:0] CREDIT_ONE = CREDIT_W'(1);

    state_e              state_q,       state_d;
    logic [CREDIT_W-1:0] credit_q,      credit_d;
    logic [1:0]          vend_id_q,     vend_id_d;
    logic                coin_reject_q, coin_reject_d;

    logic [NPROD-1:0]    sold_out;
    logic [3:0]          sold_out_pad;
    logic [EW-1:0]       credit_ext;
    logic [EW-1:0]       coin_units;
    logic [EW-1:0]       coin_sum;
    logic                coin_fits;
    logic                coin_present;
    logic                cancel_ok;
    logic                sel_ok;
    logic [CREDIT_W-1:0] credit_left;

    vending_inventory #(
        .NPROD   (NPROD),
        .INV_W   (INV_W),
        .INV_MAX (INV_MAX)
    ) u_inventory (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .restock_i  (restock_i),
        .dec_en_i   (state_q == VEND),
        .dec_id_i   (vend_id_q),
        .sold_out_o (sold_out)
    );

    // Product slots beyond NPROD read as sold out, so they can never be selected
    always_comb begin
        sold_out_pad                = '1;
        sold_out_pad[NPROD-1:0]     = sold_out;
    end

    // Coin decode and saturation check
    always_comb begin
        case (coin_i)
            COIN_5:  coin_units = EW'(1);
            COIN_10: coin_units = EW'(2);
            default: coin_units = '0;
        endcase
    end

    assign credit_ext   = EW'(credit_q);
    assign coin_sum     = credit_ext + coin_units;
    assign coin_fits    = (coin_sum <= EW'(CREDIT_MAX));
    assign coin_present = (coin_i != COIN_NONE);

    assign cancel_ok = cancel_i && (credit_q != '0);
    assign sel_ok    = sel_valid_i
                    && (credit_ext >= EW'(price_of(sel_i)))
                    && !sold_out_pad[sel_i];

    // Credit after paying for the latched product; selection guaranteed credit >= price
    assign credit_left = CREDIT_W'(credit_ext - EW'(price_of(vend_id_q)));

    // Next-state and datapath update
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        vend_id_d     = vend_id_q;
        coin_reject_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (cancel_ok) begin
                    state_d       = CHANGE;
                    coin_reject_d = coin_present;
                end else if (sel_ok) begin
                    state_d       = VEND;
                    vend_id_d     = sel_i;
                    coin_reject_d = coin_present;
                end else begin
                    case (coin_i)
                        COIN_5, COIN_10: begin
                            if (coin_fits) begin
                                credit_d = CREDIT_W'(coin_sum);
                            end else begin
                                coin_reject_d = 1'b1;
                            end
                        end
                        COIN_BAD: coin_reject_d = 1'b1;
                        default:  coin_reject_d = 1'b0;
                    endcase
                end
            end

            VEND: begin
                credit_d      = credit_left;
                state_d       = (credit_left != '0) ? CHANGE : IDLE;
                coin_reject_d = coin_present;
            end

            CHANGE: begin
                // The guard against zero only matters if state were ever corrupted
                credit_d      = (credit_q != '0) ? (credit_q - CREDIT_ONE) : '0;
                coin_reject_d = coin_present;
                if (credit_q <= CREDIT_ONE) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            vend_id_q     <= 2'd0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            vend_id_q     <= vend_id_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // All outputs come from registers or registered state
    assign vend_o        = (state_q == VEND);
    assign chg5_o        = (state_q == CHANGE);
    assign busy_o        = (state_q != IDLE);
    assign vend_id_o     = vend_id_q;
    assign credit_o      = credit_q;
    assign coin_reject_o = coin_reject_q;
    assign sold_out_o    = sold_out;

endmodule
